// File: rtl/regfile_sb.sv
// Two-read / two-write register file with write bypass, per-register busy scoreboard
// and a handshaked transfer port that stalls on busy source registers.
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] rd_addr1_i,
  input  logic [ADDR_W-1:0] rd_addr2_i,
  output logic [DATA_W-1:0] rd_data1_o,
  output logic [DATA_W-1:0] rd_data2_o,
  output logic              rd_busy1_o,
  output logic              rd_busy2_o,
  input  logic              we_a_i,
  input  logic [ADDR_W-1:0] wa_a_i,
  input  logic [DATA_W-1:0] wd_a_i,
  input  logic              we_b_i,
  input  logic [ADDR_W-1:0] wa_b_i,
  input  logic [DATA_W-1:0] wd_b_i,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic              xfer_req_i,
  input  logic [ADDR_W-1:0] xfer_addr_i,
  output logic              xfer_ready_o,
  output logic              xfer_valid_o,
  output logic [DATA_W-1:0] xfer_data_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] xaddr_q, xaddr_d;
  logic              xfer_valid_q, xfer_valid_d;
  logic [DATA_W-1:0] xfer_data_q, xfer_data_d;
  logic              cap;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [DATA_W-1:0] regs_d [Depth];
  logic [Depth-1:0]  busy_q, busy_d;

  // Lookup ports: 0/1 are the read ports, 2 is the transfer source.
  logic [ADDR_W-1:0] lk_addr [3];
  logic [DATA_W-1:0] lk_data [3];
  logic              lk_busy [3];

  always_comb begin
    lk_addr[0] = rd_addr1_i;
    lk_addr[1] = rd_addr2_i;
    lk_addr[2] = (state_q == StIdle) ? xfer_addr_i : xaddr_q;
    for (int k = 0; k < 3; k++) begin
      lk_data[k] = regs_q[lk_addr[k]];
      lk_busy[k] = busy_q[lk_addr[k]];
      if (BYPASS) begin
        if (we_b_i && wa_b_i == lk_addr[k]) begin
          lk_data[k] = wd_b_i;
        end else if (we_a_i && wa_a_i == lk_addr[k]) begin
          lk_data[k] = wd_a_i;
        end
        // A same-cycle write retires the producer unless a new one is issued alongside it.
        if (((we_a_i && wa_a_i == lk_addr[k]) || (we_b_i && wa_b_i == lk_addr[k])) &&
            !(issue_valid_i && issue_addr_i == lk_addr[k])) begin
          lk_busy[k] = 1'b0;
        end
      end
      if (ZERO_REG && lk_addr[k] == '0) begin
        lk_data[k] = '0;
        lk_busy[k] = 1'b0;
      end
    end
  end

  assign rd_data1_o = lk_data[0];
  assign rd_data2_o = lk_data[1];
  assign rd_busy1_o = lk_busy[0];
  assign rd_busy2_o = lk_busy[1];

  always_comb begin
    for (int i = 0; i < Depth; i++) begin
      regs_d[i] = regs_q[i];
      busy_d[i] = busy_q[i];
      if (!(ZERO_REG && i == 0)) begin
        if (we_a_i && wa_a_i == ADDR_W'(i)) begin
          regs_d[i] = wd_a_i;
          busy_d[i] = 1'b0;
        end
        if (we_b_i && wa_b_i == ADDR_W'(i)) begin
          regs_d[i] = wd_b_i;
          busy_d[i] = 1'b0;
        end
        if (issue_valid_i && issue_addr_i == ADDR_W'(i)) begin
          busy_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q <= busy_d;
    end
  end

  // Transfer FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      xaddr_q      <= '0;
      xfer_valid_q <= 1'b0;
      xfer_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      xaddr_q      <= xaddr_d;
      xfer_valid_q <= xfer_valid_d;
      xfer_data_q  <= xfer_data_d;
    end
  end

  // Transfer FSM: next state
  always_comb begin
    state_d = state_q;
    xaddr_d = xaddr_q;
    unique case (state_q)
      StIdle: begin
        if (xfer_req_i) begin
          xaddr_d = xfer_addr_i;
          if (lk_busy[2]) state_d = StWait;
        end
      end
      StWait: begin
        if (!lk_busy[2]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Transfer FSM: outputs
  always_comb begin
    xfer_ready_o = (state_q == StIdle);
    cap          = ((state_q == StIdle && xfer_req_i) || state_q == StWait) && !lk_busy[2];
    xfer_valid_d = cap;
    xfer_data_d  = cap ? lk_data[2] : xfer_data_q;
  end

  assign xfer_valid_o = xfer_valid_q;
  assign xfer_data_o  = xfer_data_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed plan with literal expectations, then random traffic
// compared every cycle against an array-based model of the register file.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rd_addr1, rd_addr2;
  logic [31:0] rd_data1, rd_data2;
  logic        rd_busy1, rd_busy2;
  logic        we_a, we_b;
  logic [4:0]  wa_a, wa_b;
  logic [31:0] wd_a, wd_b;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        xfer_req;
  logic [4:0]  xfer_addr;
  logic        xfer_ready, xfer_valid;
  logic [31:0] xfer_data;

  regfile_sb dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .rd_addr1_i    (rd_addr1),
    .rd_addr2_i    (rd_addr2),
    .rd_data1_o    (rd_data1),
    .rd_data2_o    (rd_data2),
    .rd_busy1_o    (rd_busy1),
    .rd_busy2_o    (rd_busy2),
    .we_a_i        (we_a),
    .wa_a_i        (wa_a),
    .wd_a_i        (wd_a),
    .we_b_i        (we_b),
    .wa_b_i        (wa_b),
    .wd_b_i        (wd_b),
    .issue_valid_i (issue_valid),
    .issue_addr_i  (issue_addr),
    .xfer_req_i    (xfer_req),
    .xfer_addr_i   (xfer_addr),
    .xfer_ready_o  (xfer_ready),
    .xfer_valid_o  (xfer_valid),
    .xfer_data_o   (xfer_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Model state
  logic [31:0] m_mem  [32];
  bit          m_busy [32];
  bit          m_wait;
  logic [4:0]  m_xaddr;
  bit          m_xvalid;
  logic [31:0] m_xdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_wait   = 1'b0;
    m_xaddr  = '0;
    m_xvalid = 1'b0;
    m_xdata  = '0;
  endtask

  function automatic bit writes_to(input logic [4:0] a);
    return (we_a && wa_a == a) || (we_b && wa_b == a);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return '0;
    if (we_b && wa_b == a) return wd_b;
    if (we_a && wa_a == a) return wd_a;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (writes_to(a) && !(issue_valid && issue_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  // Advance the model across one rising edge using the inputs held during the cycle.
  task automatic model_step();
    bit          v;
    logic [31:0] d;
    v = 1'b0;
    d = '0;
    if (!m_wait) begin
      if (xfer_req) begin
        if (exp_busy(xfer_addr)) begin
          m_wait  = 1'b1;
          m_xaddr = xfer_addr;
        end else begin
          v = 1'b1;
          d = exp_read(xfer_addr);
        end
      end
    end else if (!exp_busy(m_xaddr)) begin
      v      = 1'b1;
      d      = exp_read(m_xaddr);
      m_wait = 1'b0;
    end
    if (we_a && wa_a != 0) begin
      m_mem[wa_a]  = wd_a;
      m_busy[wa_a] = 1'b0;
    end
    if (we_b && wa_b != 0) begin
      m_mem[wa_b]  = wd_b;
      m_busy[wa_b] = 1'b0;
    end
    if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    m_xvalid = v;
    if (v) m_xdata = d;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_data1", rd_data1, exp_read(rd_addr1));
      chk("rd_data2", rd_data2, exp_read(rd_addr2));
      chk("rd_busy1", {31'b0, rd_busy1}, {31'b0, exp_busy(rd_addr1)});
      chk("rd_busy2", {31'b0, rd_busy2}, {31'b0, exp_busy(rd_addr2)});
      chk("xfer_ready", {31'b0, xfer_ready}, {31'b0, !m_wait});
      chk("xfer_valid", {31'b0, xfer_valid}, {31'b0, m_xvalid});
      chk("xfer_data", xfer_data, m_xdata);
    end
  end

  task automatic idle_inputs();
    we_a        = 1'b0; wa_a = '0; wd_a = '0;
    we_b        = 1'b0; wa_b = '0; wd_b = '0;
    issue_valid = 1'b0; issue_addr = '0;
    xfer_req    = 1'b0; xfer_addr = '0;
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rd_addr1 = '0;
    rd_addr2 = '0;
    idle_inputs();
    model_reset();
    chk_en = 1'b1;

    // Reset held two cycles; every register reads zero
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      @(negedge clk);
      chk("reset_read", rd_data1, 32'h0);
      if (i == 1) begin
        edge_step();
        rst_n = 1'b1;
      end
    end
    chk("reset_ready", {31'b0, xfer_ready}, 32'h1);
    edge_step();

    // Write with same-cycle bypass, then stored read
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF; rd_addr1 = 5'd5;
    @(negedge clk);
    chk("bypass_r5", rd_data1, 32'hDEADBEEF);
    edge_step();
    idle_inputs();
    @(negedge clk);
    chk("stored_r5", rd_data1, 32'hDEADBEEF);
    edge_step();

    // Zero register ignores writes and issues
    we_a = 1'b1; wa_a = 5'd0; wd_a = 32'h1234;
    issue_valid = 1'b1; issue_addr = 5'd0; rd_addr1 = 5'd0;
    @(negedge clk);
    chk("zero_data", rd_data1, 32'h0);
    edge_step();
    idle_inputs();
    @(negedge clk);
    chk("zero_data_next", rd_data1, 32'h0);
    chk("zero_busy", {31'b0, rd_busy1}, 32'h0);
    edge_step();

    // Port B wins a same-address write
    we_a = 1'b1; wa_a = 5'd7; wd_a = 32'h11;
    we_b = 1'b1; wa_b = 5'd7; wd_b = 32'h22; rd_addr2 = 5'd7;
    @(negedge clk);
    chk("conflict_bypass", rd_data2, 32'h22);
    edge_step();
    idle_inputs();
    @(negedge clk);
    chk("conflict_stored", rd_data2, 32'h22);
    edge_step();

    // Scoreboard set / same-cycle issue+write / clear
    issue_valid = 1'b1; issue_addr = 5'd9; rd_addr1 = 5'd9;
    @(negedge clk);
    chk("busy_before_issue", {31'b0, rd_busy1}, 32'h0);
    edge_step();
    idle_inputs();
    @(negedge clk);
    chk("busy_set", {31'b0, rd_busy1}, 32'h1);
    edge_step();
    we_b = 1'b1; wa_b = 5'd9; wd_b = 32'h55; issue_valid = 1'b1; issue_addr = 5'd9;
    @(negedge clk);
    chk("busy_issue_write", {31'b0, rd_busy1}, 32'h1);
    edge_step();
    idle_inputs();
    @(negedge clk);
    chk("busy_kept", {31'b0, rd_busy1}, 32'h1);
    chk("data_55", rd_data1, 32'h55);
    we_a = 1'b1; wa_a = 5'd9; wd_a = 32'h66;
    @(negedge clk);
    chk("busy_clear_bypass", {31'b0, rd_busy1}, 32'h0);
    edge_step();
    idle_inputs();
    @(negedge clk);
    chk("busy_cleared", {31'b0, rd_busy1}, 32'h0);
    chk("data_66", rd_data1, 32'h66);
    edge_step();

    // Transfer that waits on a busy source
    issue_valid = 1'b1; issue_addr = 5'd3;
    edge_step();
    idle_inputs();
    xfer_req = 1'b1; xfer_addr = 5'd3;
    @(negedge clk);
    chk("xfer_ready_idle", {31'b0, xfer_ready}, 32'h1);
    edge_step();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      xfer_req = 1'b1; xfer_addr = 5'd5;
      @(negedge clk);
      chk("wait_ready", {31'b0, xfer_ready}, 32'h0);
      chk("wait_valid", {31'b0, xfer_valid}, 32'h0);
      edge_step();
    end
    idle_inputs();
    we_b = 1'b1; wa_b = 5'd3; wd_b = 32'hCAFEF00D;
    edge_step();
    idle_inputs();
    @(negedge clk);
    chk("xfer_valid_pulse", {31'b0, xfer_valid}, 32'h1);
    chk("xfer_data_val", xfer_data, 32'hCAFEF00D);
    chk("xfer_ready_back", {31'b0, xfer_ready}, 32'h1);
    edge_step();
    @(negedge clk);
    chk("xfer_pulse_one", {31'b0, xfer_valid}, 32'h0);
    edge_step();

    // Reset while waiting abandons the transfer
    issue_valid = 1'b1; issue_addr = 5'd4;
    edge_step();
    idle_inputs();
    xfer_req = 1'b1; xfer_addr = 5'd4;
    edge_step();
    idle_inputs();
    @(negedge clk);
    chk("rst_wait_ready", {31'b0, xfer_ready}, 32'h0);
    edge_step();
    rst_n = 1'b0;
    model_reset();
    edge_step();
    edge_step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      if (i == 4) begin
        we_a = 1'b1; wa_a = 5'd4; wd_a = 32'h77;
      end else begin
        idle_inputs();
      end
      @(negedge clk);
      chk("post_rst_valid", {31'b0, xfer_valid}, 32'h0);
      chk("post_rst_ready", {31'b0, xfer_ready}, 32'h1);
      edge_step();
    end
    idle_inputs();
    for (int i = 0; i < 32; i++) begin
      rd_addr2 = 5'(i);
      @(negedge clk);
      chk("post_rst_busy", {31'b0, rd_busy2}, 32'h0);
    end
    edge_step();

    // Random traffic on a narrow address range to provoke hits and stalls
    for (int c = 0; c < 1500; c++) begin
      we_a        = ($urandom_range(0, 2) == 0);
      wa_a        = 5'($urandom_range(0, 7));
      wd_a        = $urandom;
      we_b        = ($urandom_range(0, 3) == 0);
      wa_b        = 5'($urandom_range(0, 7));
      wd_b        = $urandom;
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_addr  = 5'($urandom_range(0, 7));
      xfer_req    = ($urandom_range(0, 2) == 0);
      xfer_addr   = 5'($urandom_range(0, 7));
      rd_addr1    = 5'($urandom_range(0, 7));
      rd_addr2    = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                                 : 5'($urandom_range(0, 7));
      edge_step();
    end
    idle_inputs();
    @(negedge clk);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the single-write general register file: 2 combinational read ports, 2 write ports (A: ALU writeback, B: load/FP-transfer writeback), optional write-to-read bypass, and a per-register busy scoreboard for multi-cycle producers. The tristate GPR-to-FP path is replaced by a registered, handshaked transfer port that waits on busy registers. It sits in the ID/WB stages of the Mini-MIPS core.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 hardwired to zero (writes ignored, never busy)
BYPASS, 1, 1 = same-cycle write data forwarded to read/transfer paths

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
rd_addr1, rd_addr2  in  ADDR_W  read addresses
rd_data1, rd_data2  out  DATA_W  read data (combinational)
rd_busy1, rd_busy2  out  1  scoreboard bit of read address (combinational)
we_a  in  1  write enable, port A
wa_a  in  ADDR_W  write address, port A
wd_a  in  DATA_W  write data, port A
we_b  in  1  write enable, port B
wa_b  in  ADDR_W  write address, port B
wd_b  in  DATA_W  write data, port B
issue_valid  in  1  mark issue_addr pending (multi-cycle producer issued)
issue_addr  in  ADDR_W  destination being marked busy
xfer_req  in  1  request GPR-to-FP transfer
xfer_addr  in  ADDR_W  source register of transfer
xfer_ready  out  1  transfer port can accept xfer_req
xfer_valid  out  1  one-cycle pulse: xfer_data valid
xfer_data  out  DATA_W  transferred value (registered)

Behaviour:
- Reset (rst=0, asynchronous): all registers 0, all busy bits 0, FSM to IDLE, xfer_valid=0, xfer_data=0, xfer_ready=1. rd_data* read 0, rd_busy* read 0.
- Writes on rising clk edge. we_a and we_b to the same address in one cycle: port B wins. ZERO_REG=1: writes to address 0 dropped.
- Reads: ZERO_REG=1 and addr=0 -> 0. BYPASS=1: a read matching an active write address returns that write data (port B priority), else stored value. BYPASS=0: stored value only (new data visible the next cycle).
- Scoreboard: issue_valid sets busy[issue_addr] at the edge. A write on either port to address X clears busy[X]. Issue and write to the same X in one cycle: busy stays set (new producer wins). ZERO_REG=1: busy[0] is never set.
- rd_busy*: registered busy bit. With BYPASS=1, a same-cycle write to that address (and no same-cycle issue to it) forces 0.
- Transfer FSM, states IDLE, WAIT:
  - IDLE, xfer_ready=1. On xfer_req, latch xfer_addr.
    - Effective busy 0: next edge xfer_data <= value (bypass rules as read), xfer_valid=1 for 1 cycle, stay IDLE.
    - Effective busy 1: go to WAIT.
  - WAIT, xfer_ready=0; xfer_req is ignored.
    - Each cycle, check the latched address.
    - When a write clears it (with BYPASS=1, in the clearing cycle itself): capture the data, pulse xfer_valid next edge, return to IDLE.
    - BYPASS=0: capture one cycle after the clear.
- Latency: IDLE hit -> 1 cycle. Back-to-back requests in IDLE give a valid pulse every cycle.
- Reset mid-WAIT: transfer is abandoned; no xfer_valid is produced.

Test Plan:
- Reset then write: rst low 2 cycles; read all 32 -> 0. we_a wa_a=5 wd_a=0xDEADBEEF; read r5 same cycle -> 0xDEADBEEF (BYPASS=1); next cycle, stored read -> 0xDEADBEEF.
- Zero register: we_a wa_a=0 wd_a=0x1234 and issue_valid issue_addr=0 -> rd_data1(addr 0)=0, rd_busy1=0.
- Write conflict: we_a and we_b both to r7, wd_a=0x11, wd_b=0x22 -> r7=0x22.
- Scoreboard set/clear: issue_valid r9 -> rd_busy(r9)=1 next cycle.
  - we_b r9 0x55 with issue_valid r9 in the same cycle -> busy stays 1.
  - Next we_a r9 0x66 with no issue -> busy 0, data 0x66.
- Transfer with wait: issue r3, then xfer_req r3 -> xfer_ready=0, no valid for 4 cycles. we_b r3 0xCAFEF00D -> xfer_valid pulse with xfer_data=0xCAFEF00D, xfer_ready returns 1.
- Reset in WAIT: rst asserted during WAIT -> xfer_valid never pulses; post-reset xfer_ready=1, busy all 0.
